// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP VRAM arbiter: CPU-side transfer states,
// control-port command codes and status-byte bit positions.
package vdp_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WRITE_PEND = 2'b01,
    READ_PEND  = 2'b10,
    READ_WAIT  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CMD_SETRD = 2'b00,
    CMD_SETWR = 2'b01,
    CMD_REGWR = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_e;

  localparam int STAT_BUSY = 7;
  localparam int STAT_OVR  = 6;

  // The second control byte carries 6 address bits on top of the 8 latched ones.
  localparam int PTR_LOAD_BITS = 14;

endpackage

// File: rtl/vdp_ctrl_latch.sv
// Two-byte control-port sequencer: latches the first byte, then decodes the second
// into pointer-load, prefetch and VDP register-write strobes.
module vdp_ctrl_latch
  import vdp_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ctrl_wr,
  input  logic                     toggle_clr,
  input  logic [7:0]               data_in,
  output logic                     ptr_load,
  output logic                     prefetch,
  output logic [PTR_LOAD_BITS-1:0] ptr_val,
  output logic                     reg_wr,
  output logic [2:0]               reg_idx,
  output logic [7:0]               reg_val
);

  logic       toggle_q, toggle_d;
  logic [7:0] latch_q, latch_d;
  logic       second;
  cmd_e       cmd;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cmd      = cmd_e'(data_in[7:6]);
    second   = ctrl_wr & toggle_q;
    ptr_load = second & ((cmd == CMD_SETRD) | (cmd == CMD_SETWR));
    prefetch = second & (cmd == CMD_SETRD);
    reg_wr   = second & (cmd == CMD_REGWR);
    ptr_val  = {data_in[5:0], latch_q};
    reg_idx  = data_in[2:0];
    reg_val  = latch_q;

    toggle_d = toggle_q;
    latch_d  = latch_q;
    if (toggle_clr) begin
      toggle_d = 1'b0;
    end else if (ctrl_wr) begin
      if (!toggle_q) begin
        latch_d  = data_in;
        toggle_d = 1'b1;
      end else begin
        toggle_d = 1'b0;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_q <= 1'b0;
      latch_q  <= 8'h00;
    end else begin
      toggle_q <= toggle_d;
      latch_q  <= latch_d;
    end
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Shares the single-port VRAM between display fetch (always wins) and the CPU data
// port; decodes the control port. Optional stall counter under VDP_STALL_COUNT_EN.
module vdp_vram_arbiter
  import vdp_pkg::*;
#(
  parameter int RamBits = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dispReq,
  input  logic [RamBits-1:0] dispAddr,
  input  logic               cpuSel,
  input  logic               cpuWr,
  input  logic               cpuPort,
  input  logic [7:0]         cpuDataIn,
  output logic [7:0]         cpuDataOut,
  output logic               cpuBusy,
  output logic [RamBits-1:0] ramAddr,
  output logic               ramWe,
  output logic [7:0]         ramDataWrite,
  input  logic [7:0]         ramDataRead,
  output logic               regWe,
  output logic [2:0]         regIdx,
  output logic [7:0]         regData
`ifdef VDP_STALL_COUNT_EN
  ,
  output logic [15:0]        stallCount
`endif
);

  state_e             state_q, state_d;
  logic [RamBits-1:0] ptr_q, ptr_d;
  logic [7:0]         wr_buf_q, wr_buf_d;
  logic [7:0]         read_buf_q, read_buf_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               overrun_q, overrun_d;
  logic               reg_we_q, reg_we_d;
  logic [2:0]         reg_idx_q, reg_idx_d;
  logic [7:0]         reg_data_q, reg_data_d;

  logic busy, ctrl_rd, drop, data_wr, data_rd, ctrl_wr, ram_slot;
  logic ptr_load, prefetch, reg_wr;
  logic [PTR_LOAD_BITS-1:0] ptr_val;
  logic [2:0] reg_idx_new;
  logic [7:0] reg_val;

  // A status read is always honoured; anything else arriving while busy is dropped.
  always_comb begin
    busy     = (state_q != IDLE);
    ctrl_rd  = cpuSel & cpuPort & ~cpuWr;
    drop     = cpuSel & busy & ~ctrl_rd;
    data_wr  = cpuSel & ~busy & ~cpuPort & cpuWr;
    data_rd  = cpuSel & ~busy & ~cpuPort & ~cpuWr;
    ctrl_wr  = cpuSel & ~busy & cpuPort & cpuWr;
    ram_slot = ~dispReq & ((state_q == WRITE_PEND) | (state_q == READ_PEND));
  end

  vdp_ctrl_latch u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .ctrl_wr    (ctrl_wr),
    .toggle_clr (data_wr | data_rd | ctrl_rd),
    .data_in    (cpuDataIn),
    .ptr_load   (ptr_load),
    .prefetch   (prefetch),
    .ptr_val    (ptr_val),
    .reg_wr     (reg_wr),
    .reg_idx    (reg_idx_new),
    .reg_val    (reg_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (data_wr)                  state_d = WRITE_PEND;
        else if (data_rd || prefetch) state_d = READ_PEND;
      end
      WRITE_PEND: if (!dispReq) state_d = IDLE;
      READ_PEND:  if (!dispReq) state_d = READ_WAIT;
      READ_WAIT:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ramAddr      = dispReq ? dispAddr : ptr_q;
    ramWe        = (state_q == WRITE_PEND) & ~dispReq;
    ramDataWrite = wr_buf_q;
    cpuBusy      = busy;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ptr_load)      ptr_d = RamBits'(ptr_val);
    else if (ram_slot) ptr_d = ptr_q + RamBits'(1);

    wr_buf_d   = data_wr ? cpuDataIn : wr_buf_q;
    read_buf_d = (state_q == READ_WAIT) ? ramDataRead : read_buf_q;

    // A data read returns the buffered byte; the fetch it starts refills the buffer.
    data_out_d = data_out_q;
    if (data_rd) begin
      data_out_d = read_buf_q;
    end else if (ctrl_rd) begin
      data_out_d            = 8'h00;
      data_out_d[STAT_BUSY] = busy;
      data_out_d[STAT_OVR]  = overrun_q;
    end

    overrun_d = overrun_q;
    if (ctrl_rd)   overrun_d = 1'b0;
    else if (drop) overrun_d = 1'b1;

    reg_we_d   = reg_wr;
    reg_idx_d  = reg_wr ? reg_idx_new : reg_idx_q;
    reg_data_d = reg_wr ? reg_val : reg_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      wr_buf_q   <= 8'h00;
      read_buf_q <= 8'h00;
      data_out_q <= 8'h00;
      overrun_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_idx_q  <= 3'd0;
      reg_data_q <= 8'h00;
    end else begin
      ptr_q      <= ptr_d;
      wr_buf_q   <= wr_buf_d;
      read_buf_q <= read_buf_d;
      data_out_q <= data_out_d;
      overrun_q  <= overrun_d;
      reg_we_q   <= reg_we_d;
      reg_idx_q  <= reg_idx_d;
      reg_data_q <= reg_data_d;
    end
  end

  assign cpuDataOut = data_out_q;
  assign regWe      = reg_we_q;
  assign regIdx     = reg_idx_q;
  assign regData    = reg_data_q;

`ifdef VDP_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (ctrl_rd)                                      stall_d = 16'h0000;
    else if (busy && dispReq && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= 16'h0000;
    else        stall_q <= stall_d;
  end

  assign stallCount = stall_q;
`endif

endmodule
